// File: rtl/mini_cpu_sequencer_if.sv
// Host, program-load and datapath signals of the mini CPU sequencer.
// The sequencer connects through the slave modport; the host/datapath side uses master.
interface mini_cpu_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic              busy;
    logic              done;
    logic              prog_err;
    logic [ADDR_W-1:0] pc;
    logic              cpu_write_enable;
    logic [3:0]        cpu_write_data;
    logic [2:0]        cpu_opcode;
    logic [3:0]        cpu_result;
    logic              cpu_zero;
    logic              res_valid;
    logic [3:0]        res_data;
    logic              res_zero;

    modport slave (
        input  start, prog_we, prog_addr, prog_data, cpu_result, cpu_zero,
        output busy, done, prog_err, pc, cpu_write_enable, cpu_write_data,
               cpu_opcode, res_valid, res_data, res_zero
    );

    modport master (
        output start, prog_we, prog_addr, prog_data, cpu_result, cpu_zero,
        input  busy, done, prog_err, pc, cpu_write_enable, cpu_write_data,
               cpu_opcode, res_valid, res_data, res_zero
    );
endinterface

// File: rtl/mini_cpu_sequencer.sv
// Steps a host-loaded program into the datapath: 2 cycles per NOP/LOAD, 4 per EXEC, then DONE.
// No backpressure; program writes are refused while a run is in flight.
module mini_cpu_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input logic                 clk,
    input logic                 reset,
    mini_cpu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [1:0]        C_NOP   = 2'b00;
    localparam logic [1:0]        C_LOAD  = 2'b01;
    localparam logic [1:0]        C_EXEC  = 2'b10;
    localparam logic [1:0]        C_HALT  = 2'b11;
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);

    state_t            state_q, state_d;
    // Only class bits [7:6] and operand bits [3:0] matter, so only those are stored.
    logic [5:0]        mem [PROG_DEPTH];
    logic [5:0]        ir_q;
    logic [1:0]        ir_cls;
    logic [ADDR_W-1:0] pc_q;
    logic              prog_err_q;
    logic              res_valid_q;
    logic [3:0]        res_data_q;
    logic              res_zero_q;
    logic              busy;
    logic              advance;
    logic              pc_inc;
    logic              write_enable;
    logic [3:0]        write_data;
    logic [2:0]        opcode;

    assign ir_cls = ir_q[5:4];
    assign busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                    (state_q == S_SETTLE) || (state_q == S_CAPTURE);

    always_comb begin
        state_d      = state_q;
        advance      = 1'b0;
        pc_inc       = 1'b0;
        write_enable = 1'b0;
        write_data   = 4'd0;
        opcode       = 3'd0;
        unique case (state_q)
            S_IDLE:    if (bus.start) state_d = S_FETCH;
            S_FETCH:   state_d = S_ISSUE;
            S_ISSUE: begin
                unique case (ir_cls)
                    C_NOP:  advance = 1'b1;
                    C_LOAD: begin
                        write_enable = 1'b1;
                        write_data   = ir_q[3:0];
                        advance      = 1'b1;
                    end
                    C_EXEC: begin
                        opcode  = ir_q[2:0];
                        state_d = S_SETTLE;
                    end
                    C_HALT: state_d = S_DONE;
                endcase
            end
            S_SETTLE: begin
                opcode  = ir_q[2:0];
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                opcode  = ir_q[2:0];
                advance = 1'b1;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // The last address ends the run instead of wrapping back to 0.
        if (advance) begin
            if (pc_q == LAST_PC) begin
                state_d = S_DONE;
            end else begin
                pc_inc  = 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            prog_err_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'd0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= (state_q == S_CAPTURE);
            if (state_q == S_FETCH) ir_q <= mem[pc_q];
            if (state_q == S_CAPTURE) begin
                res_data_q <= bus.cpu_result;
                res_zero_q <= bus.cpu_zero;
            end
            if ((state_q == S_IDLE) && bus.start) begin
                pc_q       <= '0;
                prog_err_q <= 1'b0;
            end else if (pc_inc) begin
                pc_q <= pc_q + 1'b1;
            end
            if (busy && bus.prog_we) prog_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.prog_we && !busy) mem[bus.prog_addr] <= {bus.prog_data[7:6], bus.prog_data[3:0]};
    end

    assign bus.busy             = busy;
    assign bus.done             = (state_q == S_DONE);
    assign bus.prog_err         = prog_err_q;
    assign bus.pc               = pc_q;
    assign bus.cpu_write_enable = write_enable;
    assign bus.cpu_write_data   = write_data;
    assign bus.cpu_opcode       = opcode;
    assign bus.res_valid        = res_valid_q;
    assign bus.res_data         = res_data_q;
    assign bus.res_zero         = res_zero_q;
endmodule

// File: tb/tb_mini_cpu_sequencer.sv
// Directed bench for mini_cpu_sequencer; the bench plays host and a constant datapath stub.
module tb_mini_cpu_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mini_cpu_sequencer_if #(.ADDR_W(4)) bus ();
    mini_cpu_sequencer #(.PROG_DEPTH(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          w_done_at, w_busy_cnt, w_op_cnt, w_rv_cnt, w_stray, w_we_cnt, w_pc_max, w_pc_drop;
    logic        w_done_busy, w_rv_zero;
    logic [2:0]  w_op_val;
    logic [3:0]  w_rv_dat;
    logic [15:0] w_we_hist;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Observes cycles c0..limit (cycle 0 = start cycle) and stops at the done pulse.
    task automatic watch(input int c0, input int limit);
        int prev_pc;
        w_done_at = -1; w_busy_cnt = 0; w_op_cnt = 0; w_rv_cnt = 0; w_stray = 0;
        w_we_cnt = 0; w_pc_max = 0; w_pc_drop = 0; w_done_busy = 1'b0; w_rv_zero = 1'b0;
        w_op_val = 3'd0; w_rv_dat = 4'd0; w_we_hist = 16'd0;
        prev_pc = int'(bus.pc);
        for (int c = c0; c <= limit; c++) begin
            if (bus.cpu_write_enable) begin
                w_we_cnt++;
                w_we_hist = {w_we_hist[11:0], bus.cpu_write_data};
            end else if (bus.cpu_write_data != 4'd0) begin
                w_stray++;
            end
            if (bus.cpu_opcode != 3'd0) begin
                w_op_cnt++;
                w_op_val = bus.cpu_opcode;
            end
            if (bus.res_valid) begin
                w_rv_cnt++;
                w_rv_dat  = bus.res_data;
                w_rv_zero = bus.res_zero;
            end
            if (bus.busy) w_busy_cnt++;
            if (int'(bus.pc) > w_pc_max) w_pc_max = int'(bus.pc);
            if (int'(bus.pc) < prev_pc) w_pc_drop++;
            prev_pc = int'(bus.pc);
            if (bus.done) begin
                w_done_at   = c;
                w_done_busy = bus.busy;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int n_done;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = 4'd0;
        bus.prog_data  = 8'd0;
        bus.cpu_result = 4'd0;
        bus.cpu_zero   = 1'b0;
        tick();
        tick();
        check_val("rst_pc", bus.pc, 0);
        check_val("rst_flags", {bus.busy, bus.done, bus.prog_err, bus.res_valid, bus.res_zero}, 0);
        check_val("rst_cpu", {bus.cpu_write_enable, bus.cpu_write_data, bus.cpu_opcode}, 0);
        check_val("rst_res_data", bus.res_data, 0);
        reset = 1'b0;

        // LOAD 5, LOAD 3, EXEC 000, HALT; stub returns A, zero=0
        prog_write(4'd0, 8'h45);
        prog_write(4'd1, 8'h43);
        prog_write(4'd2, 8'h80);
        prog_write(4'd3, 8'hC0);
        bus.cpu_result = 4'hA;
        bus.cpu_zero   = 1'b0;
        pulse_start();
        check_val("t1_busy_c1", bus.busy, 1);
        watch(1, 40);
        check_val("t1_done_at", w_done_at, 11);
        check_val("t1_we_cnt", w_we_cnt, 2);
        check_val("t1_we_data", w_we_hist, 16'h0053);
        check_val("t1_stray_wdata", w_stray, 0);
        check_val("t1_rv_cnt", w_rv_cnt, 1);
        check_val("t1_rv_data", {w_rv_dat, w_rv_zero}, {4'hA, 1'b0});
        check_val("t1_busy_cnt", w_busy_cnt, 10);
        check_val("t1_busy_at_done", w_done_busy, 0);
        check_val("t1_pc_at_done", bus.pc, 3);
        tick();
        check_val("t1_done_pulse", bus.done, 0);

        // EXEC 101 then HALT; stub returns 0, zero=1
        prog_write(4'd0, 8'h85);
        prog_write(4'd1, 8'hC0);
        bus.cpu_result = 4'h0;
        bus.cpu_zero   = 1'b1;
        pulse_start();
        watch(1, 40);
        check_val("t2_done_at", w_done_at, 7);
        check_val("t2_op_cycles", w_op_cnt, 3);
        check_val("t2_op_val", w_op_val, 3'b101);
        check_val("t2_rv", {w_rv_cnt[3:0], w_rv_dat, w_rv_zero}, {4'd1, 4'h0, 1'b1});
        check_val("t2_we_cnt", w_we_cnt, 0);
        tick();

        // 16 NOPs, some with unused bits set; run must stop at the last address
        for (int a = 0; a < 16; a++) prog_write(4'(a), (a % 2 == 1) ? 8'h3F : 8'h00);
        pulse_start();
        watch(1, 60);
        check_val("t3_done_at", w_done_at, 33);
        check_val("t3_busy_cnt", w_busy_cnt, 32);
        check_val("t3_busy_at_done", w_done_busy, 0);
        check_val("t3_pc_max", w_pc_max, 15);
        check_val("t3_pc_wrap", w_pc_drop, 0);
        check_val("t3_pc_at_done", bus.pc, 15);
        check_val("t3_quiet_cpu", {w_we_cnt[3:0], w_op_cnt[3:0], w_stray[3:0]}, 0);
        check_val("t3_res_hold", {bus.res_data, bus.res_zero}, {4'h0, 1'b1});
        tick();

        // Mid-run start and program write are refused
        prog_write(4'd0, 8'h45);
        prog_write(4'd1, 8'h43);
        prog_write(4'd2, 8'h80);
        prog_write(4'd3, 8'hC0);
        bus.cpu_result = 4'hA;
        bus.cpu_zero   = 1'b0;
        pulse_start();
        tick();
        tick();
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd2;
        bus.prog_data = 8'hC0;
        tick();
        bus.start     = 1'b0;
        bus.prog_we   = 1'b0;
        check_val("t4_prog_err_set", bus.prog_err, 1);
        watch(4, 40);
        check_val("t4_done_at", w_done_at, 11);
        check_val("t4_rv_cnt", w_rv_cnt, 1);
        tick();
        check_val("t4_prog_err_sticky", {bus.prog_err, bus.busy}, 2'b10);
        pulse_start();
        check_val("t4_prog_err_clr", bus.prog_err, 0);
        watch(1, 40);
        check_val("t4_rerun_done_at", w_done_at, 11);
        tick();

        // Reset during SETTLE aborts silently
        prog_write(4'd0, 8'hB5);
        prog_write(4'd1, 8'hC0);
        bus.cpu_result = 4'h6;
        bus.cpu_zero   = 1'b0;
        pulse_start();
        tick();
        tick();
        check_val("t5_settle_op", bus.cpu_opcode, 3'b101);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t5_rst_pc", bus.pc, 0);
        check_val("t5_rst_flags", {bus.busy, bus.done, bus.prog_err, bus.res_valid, bus.res_zero}, 0);
        check_val("t5_rst_cpu", {bus.cpu_write_enable, bus.cpu_write_data, bus.cpu_opcode}, 0);
        check_val("t5_rst_res_data", bus.res_data, 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done || bus.busy) n_done++;
            tick();
        end
        check_val("t5_no_done", n_done, 0);
        pulse_start();
        watch(1, 40);
        check_val("t5_done_at", w_done_at, 7);
        check_val("t5_rv", {w_rv_cnt[3:0], w_rv_dat, w_rv_zero}, {4'd1, 4'h6, 1'b0});
        tick();

        // Write HALT to addr 0 in the same cycle as start
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = 8'hC0;
        bus.start     = 1'b1;
        tick();
        bus.prog_we   = 1'b0;
        bus.start     = 1'b0;
        watch(1, 20);
        check_val("t6_done_at", w_done_at, 3);
        check_val("t6_no_exec", {w_op_cnt[3:0], w_rv_cnt[3:0]}, 0);
        check_val("t6_prog_err", bus.prog_err, 0);
        tick();
        check_val("t6_idle", {bus.done, bus.busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
